// File: rtl/acq_shot_if.sv
// Shot-sequencer signal bundle: shot control and charger status toward the sequencer,
// HV/pulse/sample control and status back out.
interface acq_shot_if #(
  parameter int SKIP_W = 8
);
  logic              burst_syn;
  logic              seq_en;
  logic              done_h_n;
  logic              done_l_n;
  logic              fault_h_n;
  logic              fault_l_n;
  logic              protect_state;
  logic [15:0]       sample_delay;
  logic [31:0]       sample_len;
  logic              arm_read_over;
  logic              charge_en;
  logic              fire;
  logic              sample_en;
  logic              data_ready;
  logic              busy;
  logic [1:0]        err_code;
  logic [SKIP_W-1:0] skip_cnt;

  modport master (
    output burst_syn, seq_en, done_h_n, done_l_n, fault_h_n, fault_l_n,
           protect_state, sample_delay, sample_len, arm_read_over,
    input  charge_en, fire, sample_en, data_ready, busy, err_code, skip_cnt
  );

  modport slave (
    input  burst_syn, seq_en, done_h_n, done_l_n, fault_h_n, fault_l_n,
           protect_state, sample_delay, sample_len, arm_read_over,
    output charge_en, fire, sample_en, data_ready, busy, err_code, skip_cnt
  );
endinterface

// File: rtl/acq_shot_sequencer.sv
// Per-shot scheduler for the EMAT front end: charger check, fire, receive delay,
// sample window, then hold data_ready until the ARM has drained the FIFO.
module acq_shot_sequencer #(
  parameter int DONE_TIMEOUT = 10_000_000,
  parameter int SYNC_STAGES  = 2,
  parameter int SKIP_W       = 8
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  acq_shot_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHG_WAIT, S_FIRE, S_DELAY, S_SAMPLE, S_HOLD, S_ERROR
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(DONE_TIMEOUT - 1);

  state_t            state, nxt;
  logic [3:0]        sync_p [SYNC_STAGES];
  logic [3:0]        sync_out;
  logic              done_both, fault_any;
  logic [31:0]       cnt;
  logic [15:0]       delay_cap;
  logic [31:0]       len_cap;
  logic              charge_en_r, fire_r, sample_en_r, data_ready_r, busy_r;
  logic [1:0]        err_code_r;
  logic [SKIP_W-1:0] skip_cnt_r;

  // Charger status is asynchronous; bit order {fault_l, fault_h, done_l, done_h}.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '1;
    end else begin
      sync_p[0] <= {bus.fault_l_n, bus.fault_h_n, bus.done_l_n, bus.done_h_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign sync_out  = sync_p[SYNC_STAGES-1];
  assign done_both = ~sync_out[0] & ~sync_out[1];
  assign fault_any = ~sync_out[2] | ~sync_out[3];

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (bus.burst_syn && bus.seq_en) nxt = bus.protect_state ? S_ERROR : S_CHG_WAIT;
      S_CHG_WAIT:
        if (!bus.seq_en)          nxt = S_IDLE;
        else if (fault_any)       nxt = S_ERROR;
        else if (done_both)       nxt = S_FIRE;
        else if (cnt == TMO_LAST) nxt = S_ERROR;
      S_FIRE:
        if (!bus.seq_en)          nxt = S_IDLE;
        else if (delay_cap != '0) nxt = S_DELAY;
        else                      nxt = (len_cap == '0) ? S_IDLE : S_SAMPLE;
      S_DELAY:
        if (!bus.seq_en)          nxt = S_IDLE;
        else if (cnt == '0)       nxt = (len_cap == '0) ? S_IDLE : S_SAMPLE;
      S_SAMPLE:
        if (!bus.seq_en)          nxt = S_IDLE;
        else if (cnt == '0)       nxt = S_HOLD;
      S_HOLD:
        if (!bus.seq_en || bus.arm_read_over) nxt = S_IDLE;
      S_ERROR:
        if (!bus.seq_en)          nxt = S_IDLE;
      default:                    nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      delay_cap    <= '0;
      len_cap      <= '0;
      charge_en_r  <= 1'b0;
      fire_r       <= 1'b0;
      sample_en_r  <= 1'b0;
      data_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      err_code_r   <= 2'd0;
      skip_cnt_r   <= '0;
    end else begin
      state <= nxt;

      if (nxt != state) begin
        case (nxt)
          S_DELAY:  cnt <= {16'd0, delay_cap} - 32'd1;
          S_SAMPLE: cnt <= len_cap - 32'd1;
          default:  cnt <= '0;
        endcase
      end else if (state == S_CHG_WAIT) begin
        cnt <= cnt + 32'd1;
      end else if (state == S_DELAY || state == S_SAMPLE) begin
        cnt <= cnt - 32'd1;
      end

      // Shot timing is frozen at fire so register writes mid-shot cannot tear the window.
      if (nxt == S_FIRE) begin
        delay_cap <= bus.sample_delay;
        len_cap   <= bus.sample_len;
      end

      charge_en_r  <= (nxt == S_IDLE) ? bus.seq_en : (nxt == S_CHG_WAIT || nxt == S_HOLD);
      fire_r       <= (nxt == S_FIRE);
      sample_en_r  <= (nxt == S_SAMPLE);
      data_ready_r <= (nxt == S_HOLD);
      busy_r       <= !(nxt == S_IDLE || nxt == S_ERROR);

      if (nxt == S_ERROR) begin
        if (state != S_ERROR)
          err_code_r <= (state == S_IDLE) ? 2'd3 : (fault_any ? 2'd2 : 2'd1);
      end else begin
        err_code_r <= 2'd0;
      end

      if (bus.burst_syn && busy_r && skip_cnt_r != '1)
        skip_cnt_r <= skip_cnt_r + SKIP_W'(1);
    end
  end

  assign bus.charge_en  = charge_en_r;
  assign bus.fire       = fire_r;
  assign bus.sample_en  = sample_en_r;
  assign bus.data_ready = data_ready_r;
  assign bus.busy       = busy_r;
  assign bus.err_code   = err_code_r;
  assign bus.skip_cnt   = skip_cnt_r;

endmodule

// File: tb/tb_acq_shot_sequencer.sv
// Bench for acq_shot_sequencer: vector table for IDLE decisions, arithmetic shot-timeline
// reference for directed and random shots, hand sequences for timeout, fault, abort, overrun, reset.
module tb_acq_shot_sequencer;
  localparam int TMO     = 1000;
  localparam int SYNC    = 2;
  localparam int SKW     = 8;
  localparam int SKIPMAX = (1 << SKW) - 1;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  acq_shot_if #(.SKIP_W(SKW)) bus ();

  acq_shot_sequencer #(
    .DONE_TIMEOUT(TMO),
    .SYNC_STAGES (SYNC),
    .SKIP_W      (SKW)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int skip_exp = 0;

  typedef struct {
    bit         seq_en;
    bit         burst;
    bit         prot;
    bit         exp_charge;
    bit         exp_busy;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SKIPMAX) ? SKIPMAX : v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.charge_en, bus.fire, bus.sample_en, bus.data_ready, bus.busy, bus.err_code};
  endfunction

  task automatic idle_inputs();
    bus.burst_syn     = 1'b0;
    bus.done_h_n      = 1'b1;
    bus.done_l_n      = 1'b1;
    bus.fault_h_n     = 1'b1;
    bus.fault_l_n     = 1'b1;
    bus.protect_state = 1'b0;
    bus.arm_read_over = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  // One shot against the timeline: done first sampled at edge kd, read-over at hold start + ro
  // (ro < 0: already high), optional burst on the exit edge. Edge 0 samples the starting burst.
  task automatic run_shot(input int kd, input int d, input int l, input int ro,
                          input bit xb, input string tag);
    int ef, es, eh, er, eend;
    bit bad;
    int bad_r;
    logic [6:0] exp_o, got_o, bad_got, bad_exp;
    ef   = (kd + SYNC > 1) ? kd + SYNC : 1;
    es   = ef + 1 + d;
    eh   = es + l;
    er   = (ro < 0) ? 0 : eh + ro;
    eend = (l == 0) ? es : ((eh + 1 > er) ? eh + 1 : er);
    bus.seq_en        = 1'b1;
    bus.burst_syn     = 1'b1;
    bus.sample_delay  = 16'(d);
    bus.sample_len    = 32'(l);
    bus.done_h_n      = (kd == 0) ? 1'b0 : 1'b1;
    bus.done_l_n      = (kd == 0) ? 1'b0 : 1'b1;
    bus.arm_read_over = (er <= 0);
    bad = 1'b0; bad_r = 0; bad_got = '0; bad_exp = '0; exp_o = '0; got_o = '0;
    for (int r = 0; r <= eend + 3; r++) begin
      int q;
      @(posedge clk_sys); #1;
      q = r + 1;
      bus.burst_syn = xb && (q == eend);
      if (q >= kd) begin
        bus.done_h_n = 1'b0;
        bus.done_l_n = 1'b0;
      end
      bus.arm_read_over = (q >= er);
      if (r >= ef) begin
        bus.sample_delay = 16'($urandom);
        bus.sample_len   = 32'($urandom_range(0, 3000));
      end
      @(negedge clk_sys);
      exp_o = {!(r >= ef && r < eh), r == ef, l != 0 && r >= es && r < eh,
               l != 0 && r >= eh && r < eend, r < eend, 2'b00};
      got_o = outs();
      if (!bad && got_o !== exp_o) begin
        bad = 1'b1; bad_r = r; bad_got = got_o; bad_exp = exp_o;
      end
    end
    if (bad) check($sformatf("%s wave at cycle %0d", tag, bad_r), bad_got, bad_exp);
    else     check($sformatf("%s wave", tag), got_o, exp_o);
    if (xb) skip_exp = sat(skip_exp + 1);
    check($sformatf("%s skip_cnt", tag), bus.skip_cnt, skip_exp);
    @(posedge clk_sys); #1;
    idle_inputs();
    cycles(SYNC + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit, fires, err4, err5, busy5, dr_seen, sent, mid;
    idle_inputs();
    bus.seq_en       = 1'b0;
    bus.sample_delay = '0;
    bus.sample_len   = '0;

    vt[0] = '{0, 0, 0, 0, 0, 2'd0};
    vt[1] = '{1, 0, 0, 1, 0, 2'd0};
    vt[2] = '{0, 1, 1, 0, 0, 2'd0};
    vt[3] = '{1, 1, 0, 1, 1, 2'd0};
    vt[4] = '{1, 1, 1, 0, 0, 2'd3};
    vt[5] = '{1, 0, 1, 1, 0, 2'd0};

    cycles(3);
    check("reset outputs", outs(), 7'd0);
    check("reset skip_cnt", bus.skip_cnt, 0);
    reset_n = 1'b1;
    cycles(2);

    foreach (vt[i]) begin
      bus.seq_en        = vt[i].seq_en;
      bus.burst_syn     = vt[i].burst;
      bus.protect_state = vt[i].prot;
      @(posedge clk_sys); #1;
      bus.seq_en = 1'b0; bus.burst_syn = 1'b0; bus.protect_state = 1'b0;
      @(negedge clk_sys);
      check($sformatf("vec%0d charge/busy/err", i), {bus.charge_en, bus.busy, bus.err_code},
            {vt[i].exp_charge, vt[i].exp_busy, vt[i].exp_err});
      cycles(2);
      check($sformatf("vec%0d recover", i), {bus.busy, bus.err_code}, 3'd0);
    end
    check("table skip_cnt", bus.skip_cnt, 0);

    run_shot(50, 10, 100, 337, 1'b0, "normal");
    run_shot(5, 0, 20, 3, 1'b0, "delay0");
    run_shot(2, 6, 0, -1, 1'b0, "len0");
    run_shot(0, 0, 0, -1, 1'b1, "delay0 len0 exit burst");
    run_shot(4, 3, 12, -1, 1'b1, "preset read-over exit burst");
    run_shot(1, 1, 1, 0, 1'b0, "one-cycle window");

    for (int i = 0; i < 40; i++) begin
      int kd, d, l, ro;
      kd = $urandom_range(0, 30);
      d  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      l  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
      ro = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 10);
      run_shot(kd, d, l, ro, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Timeout with done held high
    bus.seq_en = 1'b1; bus.burst_syn = 1'b1;
    @(posedge clk_sys); #1;
    bus.burst_syn = 1'b0;
    hit = -1;
    for (int r = 0; r <= TMO + 20; r++) begin
      if (r > 0) begin @(posedge clk_sys); #1; end
      @(negedge clk_sys);
      if (bus.err_code != 2'd0) begin hit = r; break; end
    end
    check("timeout cycle", hit, TMO);
    check("timeout err/charge/busy", {bus.err_code, bus.charge_en, bus.busy}, {2'd1, 2'b00});
    @(posedge clk_sys); #1;
    bus.burst_syn = 1'b1;
    @(posedge clk_sys); #1;
    bus.burst_syn = 1'b0;
    cycles(1);
    check("error ignores burst", {bus.err_code, bus.busy}, {2'd1, 1'b0});
    check("error burst not skipped", bus.skip_cnt, skip_exp);
    bus.seq_en = 1'b0;
    cycles(1);
    check("error clear", {bus.err_code, bus.busy, bus.charge_en}, 4'd0);
    idle_inputs();
    cycles(SYNC + 2);

    // Fault and done arrive together
    bus.seq_en = 1'b1; bus.burst_syn = 1'b1;
    fires = 0; err4 = 0; err5 = 0; busy5 = 1;
    for (int r = 0; r <= 10; r++) begin
      @(posedge clk_sys); #1;
      bus.burst_syn = 1'b0;
      if (r + 1 == 3) begin
        bus.done_h_n = 1'b0; bus.done_l_n = 1'b0; bus.fault_l_n = 1'b0;
      end
      @(negedge clk_sys);
      fires += int'(bus.fire);
      if (r == 4) err4 = int'(bus.err_code);
      if (r == 5) begin err5 = int'(bus.err_code); busy5 = int'(bus.busy); end
    end
    check("fault no fire", fires, 0);
    check("fault not before sync", err4, 0);
    check("fault err_code", err5, 2);
    check("fault busy", busy5, 0);
    @(posedge clk_sys); #1;
    bus.seq_en = 1'b0;
    idle_inputs();
    cycles(SYNC + 2);

    // Abort mid-sample
    bus.seq_en = 1'b1; bus.burst_syn = 1'b1;
    bus.done_h_n = 1'b0; bus.done_l_n = 1'b0;
    bus.sample_delay = 16'd2; bus.sample_len = 32'd50;
    dr_seen = 0;
    for (int r = 0; r <= 60; r++) begin
      @(posedge clk_sys); #1;
      bus.burst_syn = 1'b0;
      if (r == 20) bus.seq_en = 1'b0;
      @(negedge clk_sys);
      if (r == 20) check("abort sampling before", bus.sample_en, 1'b1);
      if (r == 21) check("abort drop", {bus.sample_en, bus.busy, bus.charge_en}, 3'd0);
      dr_seen |= int'(bus.data_ready);
    end
    check("abort no data_ready", dr_seen, 0);
    @(posedge clk_sys); #1;
    idle_inputs();
    cycles(SYNC + 2);

    // Overrun: 300 bursts inside a long window
    bus.seq_en = 1'b1; bus.burst_syn = 1'b1;
    bus.done_h_n = 1'b0; bus.done_l_n = 1'b0;
    bus.sample_delay = 16'd0; bus.sample_len = 32'd2000;
    sent = 0; mid = -1;
    for (int r = 0; r <= 700; r++) begin
      @(posedge clk_sys); #1;
      bus.burst_syn = (r >= 4) && (r % 2 == 0) && (sent < 300);
      if (bus.burst_syn) sent++;
      @(negedge clk_sys);
      if (r == 204) mid = int'(bus.skip_cnt);
    end
    check("overrun busy", bus.busy, 1'b1);
    check("overrun skip mid", mid, sat(skip_exp + 100));
    check("overrun skip saturated", bus.skip_cnt, sat(skip_exp + 300));
    skip_exp = sat(skip_exp + 300);
    @(posedge clk_sys); #1;
    bus.seq_en = 1'b0;
    idle_inputs();
    cycles(SYNC + 2);

    // Asynchronous reset inside the sample window
    bus.seq_en = 1'b1; bus.burst_syn = 1'b1;
    bus.done_h_n = 1'b0; bus.done_l_n = 1'b0;
    bus.sample_delay = 16'd0; bus.sample_len = 32'd100;
    for (int r = 0; r <= 10; r++) begin
      @(posedge clk_sys); #1;
      bus.burst_syn = 1'b0;
    end
    @(negedge clk_sys);
    check("pre-reset sampling", {bus.sample_en, bus.busy}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset outputs", outs(), 7'd0);
    check("async reset skip_cnt", bus.skip_cnt, 0);
    @(posedge clk_sys); #1;
    bus.seq_en = 1'b0;
    idle_inputs();
    reset_n = 1'b1;
    cycles(2);
    check("post-reset idle", outs(), 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
